// File: rtl/name_key_packer.sv
// Packs a byte-serial NDN name component into 64-bit hash keys.
// Ports: clk/rst, in_* byte stream (valid/ready), key_* chunk stream (valid/ready).
module name_key_packer #(
  parameter int MAX_BYTES = 7,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [63:0]      key_data,
  output logic [5:0]       key_len,
  output logic             key_last,
  output logic [IDX_W-1:0] key_idx,
  output logic             key_ovf
);

  typedef enum logic {
    FILL,
    EMIT
  } state_t;

  localparam logic [2:0]       LAST_SLOT = 3'(MAX_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = '1;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_inc;
  logic [63:0] acc;
  logic [63:0] acc_wr;
  logic        take;
  logic        give;
  logic        done;

  assign in_ready  = (state == FILL) && !rst;
  assign key_valid = (state == EMIT);
  assign take      = in_valid && in_ready;
  assign give      = key_valid && key_ready;
  assign cnt_inc   = cnt + 3'd1;
  assign done      = in_last || (cnt == LAST_SLOT);

  // Accumulator with the incoming byte dropped into slot cnt.
  always_comb begin
    acc_wr = acc;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (cnt == 3'(k)) acc_wr[8*k +: 8] = in_byte;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (take && done) state_nx = EMIT;
      EMIT: if (key_ready)    state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      key_data <= '0;
      key_len  <= '0;
      key_last <= 1'b0;
      key_idx  <= '0;
      key_ovf  <= 1'b0;
    end else begin
      if (take) begin
        if (done) begin
          key_data <= acc_wr;
          key_len  <= {cnt_inc, 3'b000};
          key_last <= in_last;
          cnt      <= '0;
          acc      <= '0;
        end else begin
          acc <= acc_wr;
          cnt <= cnt_inc;
        end
      end
      if (give) begin
        if (key_last) begin
          key_idx <= '0;
          key_ovf <= 1'b0;
        end else if (key_idx == IDX_MAX) begin
          key_ovf <= 1'b1;
        end else begin
          key_idx <= key_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_name_key_packer.sv
// Self-checking bench for name_key_packer.
// Drives components from a queue; expected keys come from chunk arithmetic.
module tb_name_key_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = '0;
  logic        in_last = 1'b0;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic [63:0] key_data;
  logic [5:0]  key_len;
  logic        key_last;
  logic [3:0]  key_idx;
  logic        key_ovf;

  int errors = 0;
  int checks = 0;
  logic [7:0] comp[$];

  name_key_packer #(.MAX_BYTES(7), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_last(in_last),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .key_len(key_len),
    .key_last(key_last), .key_idx(key_idx),
    .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, key_valid, 0);
    chk({tag, ".data"}, key_data, 0);
    chk({tag, ".len"}, key_len, 0);
    chk({tag, ".last"}, key_last, 0);
    chk({tag, ".idx"}, key_idx, 0);
    chk({tag, ".ovf"}, key_ovf, 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    key_ready = 1'b0;
    rst = 1'b1;
    #1 chk("rst.in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("rst");
    chk("rst.in_ready_after", in_ready, 1);
    @(negedge clk);
  endtask

  // Sends comp[] as one component; stall<0 picks random backpressure.
  task automatic send_comp(input int stall, input bit bubbles);
    int n;
    int nch;
    n   = comp.size();
    nch = (n + 6) / 7;
    for (int c = 0; c < nch; c++) begin
      int st;
      int len;
      int ns;
      logic [63:0] e_data;
      logic        e_last;
      logic [3:0]  e_idx;
      logic        e_ovf;
      st     = c * 7;
      len    = (n - st < 7) ? n - st : 7;
      e_data = '0;
      for (int k = 0; k < len; k++)
        e_data = e_data | (64'(comp[st+k]) << (8 * k));
      e_last = (st + len == n);
      e_idx  = (c > 15) ? 4'd15 : 4'(c);
      e_ovf  = (c > 15);
      for (int k = 0; k < len; k++) begin
        if (bubbles && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_byte  = 8'($urandom);
          in_last  = 1'($urandom);
          @(negedge clk);
          chk("bubble.valid", key_valid, 0);
        end
        in_valid = 1'b1;
        in_byte  = comp[st+k];
        in_last  = (st + k == n - 1);
        chk("fill.in_ready", in_ready, 1);
        @(negedge clk);
      end
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      in_valid  = 1'($urandom);
      in_byte   = 8'($urandom);
      in_last   = 1'($urandom);
      key_ready = 1'b0;
      for (int s = 0; s <= ns; s++) begin
        chk("key.valid", key_valid, 1);
        chk("key.in_ready", in_ready, 0);
        chk("key.data", key_data, e_data);
        chk("key.len", key_len, 64'(8 * len));
        chk("key.last", key_last, e_last);
        chk("key.idx", key_idx, e_idx);
        chk("key.ovf", key_ovf, e_ovf);
        key_ready = (s == ns);
        @(negedge clk);
      end
      key_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post.valid", key_valid, 0);
      chk("post.in_ready", in_ready, 1);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    comp = '{8'h61, 8'h62, 8'h63};
    send_comp(0, 1'b0);

    comp = {};
    for (int i = 1; i <= 10; i++) comp.push_back(8'(i));
    send_comp(0, 1'b0);

    comp = {};
    for (int i = 8'h11; i <= 8'h17; i++) comp.push_back(8'(i));
    send_comp(0, 1'b0);
    comp = '{8'h5a};
    send_comp(0, 1'b0);

    comp = '{8'hde, 8'had, 8'hbe, 8'hef};
    send_comp(5, 1'b0);

    comp = {};
    for (int i = 0; i < 127; i++) comp.push_back(8'($urandom));
    send_comp(0, 1'b0);
    comp = '{8'h33, 8'h44};
    send_comp(0, 1'b0);

    // Reset with a partial chunk buffered.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_byte  = 8'(8'hA0 + k);
      in_last  = 1'b0;
      @(negedge clk);
    end
    do_reset();
    chk("mid.valid", key_valid, 0);
    comp = '{8'h71, 8'h72};
    send_comp(0, 1'b0);

    // Reset while a key is pending.
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_byte  = 8'(8'hC0 + k);
      in_last  = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("emit.pending", key_valid, 1);
    do_reset();
    chk("emit.dropped", key_valid, 0);

    for (int t = 0; t < 15; t++) begin
      int n;
      n = int'($urandom_range(1, 20));
      comp = {};
      for (int i = 0; i < n; i++) comp.push_back(8'($urandom));
      send_comp(-1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/name_key_packer.md
Name: name_key_packer

Overview:
- Upstream feeder for the router's 10-bit H3 hash stage.
- Accepts an NDN name component as a byte-serial valid/ready stream.
- Packs bytes into fixed-width hash keys: `key_data[63:0]` plus `key_len[5:0]` (valid bit count).
- Emits one key per chunk of up to MAX_BYTES bytes. The hash stage XOR-folds bits 0..key_len-1 of each key.

Parameters:
- MAX_BYTES, 7, bytes packed per key; legal range 1..7 so that 8*MAX_BYTES fits in 6-bit key_len.
- IDX_W, 4, width of the chunk index within a component.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept a byte this cycle
- in_byte  in  8  name byte
- in_last  in  1  byte is the final byte of the current name component
- key_valid  out  1  key outputs hold a valid chunk
- key_ready  in  1  hash stage accepts the key
- key_data  out  64  packed bytes; byte k at bits [8k+7:8k]; unused bits zero
- key_len  out  6  valid bits = 8 * bytes in chunk (8..8*MAX_BYTES)
- key_last  out  1  chunk is the final chunk of its component
- key_idx  out  IDX_W  chunk number within component, 0-based, saturating
- key_ovf  out  1  key_idx has saturated for this component (sticky until key_last handshake)

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid & in_ready at posedge clk.
  - Output transfer occurs when key_valid & key_ready.
- States:
  - FILL: in_ready=1, key_valid=0.
  - EMIT: in_ready=0, key_valid=1; all key_* outputs stable.
- FILL, on input transfer:
  - Write in_byte into byte slot cnt of the accumulator and increment cnt.
  - If in_last=1, or cnt+1 == MAX_BYTES, latch the accumulator (including this byte) into the key_* registers next cycle and go to EMIT.
  - key_last is set to in_last.
  - key_len = 8*(cnt+1).
  - cnt and the accumulator clear to 0.
- Latency: the byte that completes a chunk is accepted at edge N; key_valid=1 from edge N onward, i.e. visible in the cycle after acceptance.
- EMIT:
  - On output transfer, go to FILL.
  - If key_last=1: chunk index and key_ovf clear to 0.
  - Otherwise: chunk index increments, saturating at 2^IDX_W-1. If it was already at max, key_ovf is set to 1.
  - key_valid stays high while key_ready=0 (no drop, no change of key_* fields).
- Throughput: one chunk per (bytes + 1) cycles minimum; no input accepted while in EMIT.
- Zero-padding: accumulator bits above key_len are always 0 at key_valid.
- Component boundary: in_last on the first byte of a chunk yields key_len=8, key_last=1.
- A byte arriving with cnt+1 == MAX_BYTES and in_last=1 yields a single key with key_last=1 (no empty trailing key).
- Reset:
  - While rst=1 at posedge: state=FILL, cnt=0, accumulator=0, key_valid=0, key_data=0, key_len=0, key_last=0, key_idx=0, key_ovf=0.
  - in_ready=0 during the reset cycle, 1 afterward.
  - A reset mid-component or mid-EMIT discards the partial or pending chunk; no key is emitted for it.
- in_byte and in_last are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Single short component: bytes 0x61,0x62,0x63 (last on 0x63), key_ready=1 → one key: key_data=0x0000_0000_0063_6261, key_len=24, key_last=1, key_idx=0; key_valid rises the cycle after 0x63 is accepted.
- Multi-chunk: 10 bytes 0x01..0x0A (last on 0x0A), MAX_BYTES=7 → key0: data=0x0007_0605_0403_0201, len=56, last=0, idx=0; key1: data=0x0A_0908, len=24, last=1, idx=1.
- Exact fit: 7 bytes 0x11..0x17 with last on 0x17 → exactly one key, len=56, last=1; the next component starts at idx=0.
- Backpressure: hold key_ready=0 for 5 cycles during EMIT → in_ready=0, key_* stable throughout; key handed over on the first cycle key_ready=1; in_ready=1 the next cycle.
- Saturation: 18 chunks of 7 bytes without in_last, IDX_W=4 → idx runs 0..15 then stays 15; key_ovf=1 from the 17th key; both clear after the key_last handshake.
- Reset mid-operation: accept 4 bytes, assert rst for 1 cycle → no key emitted, all outputs 0; a following 2-byte component yields len=16, idx=0.
